// File: rtl/conv_window_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_feeder_if
// Brief    : Bundles the stream, ConvUnit and result signals of the window feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_window_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 25
);
  logic                    in_valid;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] image;
  logic                    cu_reset;
  logic                    cu_done;
  logic [DATA_WIDTH-1:0]   cu_result;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_ready;

  // master = surrounding environment (upstream, ConvUnit, downstream)
  modport master (
    output in_valid, in_data, cu_done, cu_result, out_ready,
    input  in_ready, image, cu_reset, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, cu_done, cu_result, out_ready,
    output in_ready, image, cu_reset, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_feeder
// Brief    : Packs a serial FP16 stream into a ConvUnit window, sequences the
//            unit through its reset and returns the result on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int Depth      = 1,
  parameter int Size       = 5
) (
  input wire clk,
  input wire reset,
  conv_window_feeder_if.slave bus
);
  localparam int c_N  = Depth * Size * Size;
  localparam int c_CW = $clog2(c_N + 1);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(c_N);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                    r_state;
  logic [c_CW-1:0]           r_cnt;
  logic [c_N*DATA_WIDTH-1:0] r_image;
  logic                      r_out_valid;
  logic [DATA_WIDTH-1:0]     r_out_data;
  logic                      r_cu_reset;

  logic w_in_ready;
  logic w_accept;
  logic w_complete;
  logic w_slot_free;

  always_comb begin
    w_in_ready  = (r_state == LOAD) && (r_cnt != c_FULL);
    w_accept    = w_in_ready && bus.in_valid;
    w_complete  = (r_cnt == c_FULL) || ((r_cnt == c_LAST) && w_accept);
    // Launch only when the result register will be free by the time we capture
    w_slot_free = !r_out_valid || bus.out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_image     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_cu_reset  <= 1'b1;
    end else begin
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        LOAD: begin
          r_cu_reset <= 1'b1;
          if (w_accept) begin
            // First word lands in the MSBs, last word in the LSBs
            for (int k = 0; k < c_N; k++) begin
              if (r_cnt == c_CW'(k)) begin
                r_image[(c_N-k)*DATA_WIDTH-1 -: DATA_WIDTH] <= bus.in_data;
              end
            end
            r_cnt <= r_cnt + c_CW'(1);
          end
          if (w_complete && w_slot_free) begin
            r_state    <= RUN;
            r_cu_reset <= 1'b0;
            r_cnt      <= '0;
          end
        end
        RUN: begin
          if (bus.cu_done) begin
            r_out_data  <= bus.cu_result;
            r_out_valid <= 1'b1;
            r_cu_reset  <= 1'b1;
            r_state     <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.image     = r_image;
  assign bus.cu_reset  = r_cu_reset;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
endmodule
`default_nettype wire

// File: tb/tb_conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_feeder
// Brief    : Scoreboard bench for conv_window_feeder with a stub ConvUnit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_feeder;
  localparam int DW    = 16;
  localparam int DEPTH = 1;
  localparam int SIZE  = 5;
  localparam int N     = DEPTH * SIZE * SIZE;
  localparam int WW    = N * DW;
  localparam int L     = 25;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_window_feeder_if #(.DATA_WIDTH(DW), .N(N)) bus ();

  conv_window_feeder #(.DATA_WIDTH(DW), .Depth(DEPTH), .Size(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] win[N];
  logic [WW-1:0] exp_img;
  logic          force_done = 1'b0;
  int            stub_cyc   = 0;
  int            stalls     = 0;

  task automatic check(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Order-sensitive signature standing in for the convolution result
  function automatic logic [DW-1:0] cks(input logic [WW-1:0] img);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r = {r[DW-2:0], r[DW-1]} ^ img[(N-k)*DW-1 -: DW];
    return r;
  endfunction

  function automatic logic [WW-1:0] pack_win();
    logic [WW-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[(N-k)*DW-1 -: DW] = win[k];
    return p;
  endfunction

  // Stub ConvUnit: done L cycles after reset release, held until reset returns
  always @(posedge clk) begin
    if (bus.cu_reset) stub_cyc <= 0;
    else if (stub_cyc < L) stub_cyc <= stub_cyc + 1;
  end
  assign bus.cu_done   = force_done || (!bus.cu_reset && stub_cyc == L);
  assign bus.cu_result = cks(bus.image);

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) check("extra_out", 1, 0);
      else check("result", bus.out_data, q.pop_front());
    end
  end

  task automatic rand_win();
    for (int k = 0; k < N; k++) win[k] = 16'($urandom);
    exp_img = pack_win();
  endtask

  task automatic send(input int lo, input int hi, input int gap);
    int t;
    for (int k = lo; k < hi; k++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = win[k];
      t = 0;
      while (!bus.in_ready && t < 300) begin
        stalls++;
        @(posedge clk); #1;
        t++;
      end
      if (!bus.in_ready) check("send_timeout", 0, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || bus.out_valid) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", (t < 200) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int viol;
    logic [DW-1:0] exp_a;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_image", bus.image, 0);
    check("rst_cu_reset", bus.cu_reset, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Reference window, back-to-back
    for (int k = 0; k < N; k++) win[k] = (k == N-1) ? 16'h4800 : 16'h4400;
    exp_img = pack_win();
    send(0, N, 0);
    q.push_back(cks(exp_img));
    check("ref_cu_reset_low", bus.cu_reset, 0);
    check("ref_image", bus.image, exp_img);
    check("ref_lsb", bus.image[DW-1:0], 16'h4800);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ref_latency", n, L + 1);
    check("ref_cu_reset_high", bus.cu_reset, 1);
    drain();

    // Gapped input
    rand_win();
    stalls = 0;
    send(0, N, 40);
    q.push_back(cks(exp_img));
    check("gap_no_stall", stalls, 0);
    check("gap_image", bus.image, exp_img);
    drain();

    // Input held valid during RUN
    rand_win();
    send(0, N, 0);
    q.push_back(cks(exp_img));
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hdead;
    viol = 0;
    n = 0;
    while (!bus.cu_done && n < 100) begin
      if (bus.in_ready || bus.image !== exp_img) viol++;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check("run_blocked", viol, 0);
    check("run_image", bus.image, exp_img);
    drain();

    // Backpressure: second window stalls until the first result retires
    bus.out_ready = 1'b0;
    rand_win();
    send(0, N, 0);
    exp_a = cks(exp_img);
    q.push_back(exp_a);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_a_data", bus.out_data, exp_a);
    rand_win();
    send(0, N, 0);
    q.push_back(cks(exp_img));
    check("bp_stall_ready", bus.in_ready, 0);
    check("bp_stall_cu_reset", bus.cu_reset, 1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_data", bus.out_data, exp_a);
    check("bp_hold_valid", bus.out_valid, 1);
    check("bp_hold_cu_reset", bus.cu_reset, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_retired", bus.out_valid, 0);
    check("bp_launch", bus.cu_reset, 0);
    check("bp_image", bus.image, exp_img);
    drain();

    // Reset mid-RUN
    rand_win();
    send(0, N, 0);
    q.push_back(cks(exp_img));
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_cu_reset", bus.cu_reset, 1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_image", bus.image, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    q.delete();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    rand_win();
    send(0, N, 0);
    q.push_back(cks(exp_img));
    check("post_rst_image", bus.image, exp_img);
    drain();

    // Spurious done while loading
    rand_win();
    send(0, 10, 0);
    force_done = 1'b1;
    viol = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid || !bus.cu_reset) viol++;
    end
    force_done = 1'b0;
    check("spurious_done", viol, 0);
    send(10, N, 0);
    q.push_back(cks(exp_img));
    check("spurious_image", bus.image, exp_img);
    drain();

    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/conv_window_feeder.md
# conv_window_feeder

Upstream feeder and sequencer for the FP16 `ConvUnit` in the C5 convolution layer. It takes a serial stream of FP16 activations over a valid/ready handshake and packs them into one `Depth*Size*Size` window. It starts `ConvUnit` by deasserting that unit's reset, holds the window stable while the unit runs, then captures `result` on `done` and presents it on a valid/ready output. Loading of the next window overlaps with a pending output.

## Interface
- `DATA_WIDTH`, 16, FP16 word width.
- `Depth`, 1, window depth (channels).
- `Size`, 5, filter edge length. N = `Depth*Size*Size` words per window.
- `clk`  in  1  single clock; all registers on rising edge.
- `reset`  in  1  asynchronous, active-high. Clears all state immediately.
- `in_valid`  in  1  `in_data` carries a word.
- `in_data`  in  DATA_WIDTH  FP16 activation; words arrive in window order.
- `in_ready`  out  1  word is accepted when `in_valid && in_ready` at a rising edge.
- `image`  out  N*DATA_WIDTH  packed window to `ConvUnit.image`.
- `cu_reset`  out  1  drives `ConvUnit.reset`. Registered, active-high.
- `cu_done`  in  1  from `ConvUnit.done`.
- `cu_result`  in  DATA_WIDTH  from `ConvUnit.result`.
- `out_valid`  out  1  `out_data` holds an unconsumed result.
- `out_data`  out  DATA_WIDTH  captured FP16 convolution result.
- `out_ready`  in  1  downstream accepts; transfer occurs when `out_valid && out_ready`.

## Operation
- **State and registers.**
  - States: LOAD and RUN.
  - Counter `cnt`, range 0..N; N means the window is full.
  - Registers: `image`, `out_valid`, `out_data`, `cu_reset`.
- **Packing.** The k-th accepted word (k = 0 first) is written to `image[(N-k)*DATA_WIDTH-1 -: DATA_WIDTH]`. The first word lands in the MSBs and the last word in bits [DATA_WIDTH-1:0].
- **`in_ready`** = (state==LOAD) && (cnt != N). It is combinational from registered state.
- **LOAD state.**
  - `cu_reset`=1.
  - Each accepted word is written and `cnt` increments.
  - Launch condition: window complete this cycle (cnt==N, or cnt==N-1 with an accept) AND output slot free (!out_valid || out_ready).
  - On launch: next state RUN, `cu_reset`<=0, `cnt`<=0.
  - If the window is full but the output slot is busy, stay in LOAD with cnt==N and `in_ready`=0 (stall).
- **RUN state.**
  - `cu_reset`=0, `in_ready`=0, and `image` is frozen.
  - When `cu_done`=1: `out_data`<=`cu_result`, `out_valid`<=1, `cu_reset`<=1, next state LOAD.
- **Output handshake.**
  - `out_valid` clears on `out_valid && out_ready`.
  - A capture can never coincide with a held `out_valid`, because launch requires a free slot.
  - `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- **No arithmetic.** Words pass through bit-exact with no FP16 interpretation.
- **Reset, including mid-load or mid-RUN.**
  - State returns to LOAD and `cnt`=0.
  - `image`=0, `out_valid`=0, `out_data`=0, `cu_reset`=1.
  - Any partial window or in-flight result is discarded.

## Timing
- **Reset values:** `in_ready`=1, `image`=0, `cu_reset`=1, `out_valid`=0, `out_data`=0.
- **Throughput:** one word accepted per cycle max; `in_valid` gaps are tolerated.
- **Launch latency:** last word accepted at edge t → `cu_reset` low after edge t (one register stage).
- **Capture latency:** `cu_done` sampled high at edge u → `out_valid`=1 and `cu_reset`=1 after edge u. `ConvUnit` is therefore held in reset from the cycle after capture.
- **End-to-end:** with a `ConvUnit` latency of L cycles from reset release (L=25 for Depth=1, Size=5), `out_valid` rises L+1 edges after the last word is accepted.
- **Overlap:** the next window may load during a pending output. Launch can occur in the same cycle `out_ready` retires the old result.
- **Spurious done:** `cu_done` is ignored in LOAD.

## Test plan
- **Reference window.**
  - Stimulus: reset; send 24×`16'h4400` then `16'h4800` back-to-back; pair with real `ConvUnit` and an identical filter; hold `out_ready`=1.
  - Required: `image` LSB word = `16'h4800`; `cu_reset` falls the edge after the 25th accept; `out_data`=`16'h5f00` with `out_valid` 26 edges after the last accept.
- **Gapped input.**
  - Stimulus: random `in_valid` gaps; Depth=1, Size=5.
  - Required: identical `image` packing and `16'h5f00` result; `in_ready` stays 1 until launch.
- **Backpressure stall.**
  - Stimulus: `out_ready`=0 after the first result; stream a full second window.
  - Required: second window loads, then `in_ready`=0 with cnt==N, `cu_reset` stays 1, `out_data` unchanged.
  - Then raise `out_ready` for one cycle: the old result transfers and launch happens on the same edge.
- **Input blocked in RUN.**
  - Stimulus: hold `in_valid`=1 during RUN.
  - Required: `in_ready`=0; no `image` change until capture.
- **Reset mid-RUN.**
  - Stimulus: assert `reset` 10 cycles after launch.
  - Required: immediately `cu_reset`=1, `out_valid`=0, `image`=0, `in_ready`=1; the next full window yields the correct result.
- **Spurious done.**
  - Stimulus: force `cu_done`=1 during LOAD (stub `ConvUnit`).
  - Required: no capture and `out_valid` stays 0.
